// File: rtl/spi_controller.sv
// SPI mode-0 initiator: shifts a parallel word out MSB-first on pico while capturing poci,
// with programmable sclk divider and chip-select setup/hold.
module spi_controller #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned CS_SETUP = 1,
    parameter int unsigned CS_HOLD  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic             sclk,
    output logic             cs,
    output logic             pico,
    input  logic             poci
);

    localparam int unsigned BitW  = $clog2(WIDTH) + 1;
    localparam int unsigned DivW  = $clog2(CLK_DIV) + 1;
    localparam int unsigned CsMax = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned CsW   = $clog2(CsMax) + 1;

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

    state_e             state_q, state_d;
    logic [CsW-1:0]     cs_cnt_q, cs_cnt_d;
    logic [DivW-1:0]    div_q, div_d;
    logic [BitW-1:0]    bit_q, bit_d;
    // Only the bits still to be sent; the MSB goes straight to pico on start.
    logic [WIDTH-2:0]   tx_sr_q, tx_sr_d;
    logic [WIDTH-1:0]   rx_sr_q, rx_sr_d;
    logic [WIDTH-1:0]   rx_data_q, rx_data_d;
    logic               sclk_q, sclk_d;
    logic               cs_q, cs_d;
    logic               pico_q, pico_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_comb begin
        state_d   = state_q;
        cs_cnt_d  = cs_cnt_q;
        div_d     = div_q;
        bit_d     = bit_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        pico_d    = pico_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    tx_sr_d  = tx_data[WIDTH-2:0];
                    pico_d   = tx_data[WIDTH-1];
                    cs_d     = 1'b0;
                    busy_d   = 1'b1;
                    cs_cnt_d = '0;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                if (cs_cnt_q == CsW'(CS_SETUP - 1)) begin
                    cs_cnt_d = '0;
                    div_d    = '0;
                    bit_d    = '0;
                    state_d  = StShift;
                end else begin
                    cs_cnt_d = cs_cnt_q + CsW'(1);
                end
            end
            StShift: begin
                if (div_q == DivW'(CLK_DIV - 1)) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d  = 1'b1;
                        rx_sr_d = {rx_sr_q[WIDTH-2:0], poci};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == BitW'(WIDTH - 1)) begin
                            bit_d   = '0;
                            state_d = StHold;
                        end else begin
                            bit_d   = bit_q + BitW'(1);
                            pico_d  = tx_sr_q[WIDTH-2];
                            tx_sr_d = tx_sr_q << 1;
                        end
                    end
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            StHold: begin
                if (cs_cnt_q == CsW'(CS_HOLD - 1)) begin
                    cs_cnt_d  = '0;
                    cs_d      = 1'b1;
                    pico_d    = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sr_q;
                    state_d   = StIdle;
                end else begin
                    cs_cnt_d = cs_cnt_q + CsW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cs_cnt_q  <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            pico_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cs_cnt_q  <= cs_cnt_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            pico_q    <= pico_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign cs      = cs_q;
    assign pico    = pico_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a transaction-level model predicts each transfer's result and
// completion time; a negedge monitor plays the SPI peripheral and scores every done pulse.
module tb_spi_controller;

    localparam int N   = 34;  // cs-low cycles per transfer for both instances
    localparam int N16 = 34;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, busy, done, sclk, cs, pico, poci;
    logic [7:0] tx_data, rx_data;
    logic       loop_en;
    logic [7:0] resp;
    logic       p_poci;
    assign poci = loop_en ? pico : p_poci;

    logic        start16, busy16, done16, sclk16, cs16, pico16;
    logic [15:0] tx16, rx16;

    spi_controller dut (
        .clk(clk), .reset(reset), .start(start), .tx_data(tx_data), .busy(busy),
        .done(done), .rx_data(rx_data), .sclk(sclk), .cs(cs), .pico(pico), .poci(poci)
    );

    spi_controller #(.WIDTH(16), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .tx_data(tx16), .busy(busy16),
        .done(done16), .rx_data(rx16), .sclk(sclk16), .cs(cs16), .pico(pico16),
        .poci(pico16)
    );

    typedef struct {
        logic [7:0] rx;
        logic [7:0] tx;
        int         done_at;
    } exp_t;

    typedef struct {
        logic [15:0] rx;
        int          done_at;
    } exp16_t;

    exp_t   q[$];
    exp16_t q16[$];

    int cyc = 0;
    int free_at = 0;
    int free16 = 0;
    int reset_chk_at = -1;
    bit finish_req = 1'b0;
    int checks = 0;
    int errors = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor, peripheral model and transaction model share one process.
    initial begin : monitor
        exp_t   e;
        exp16_t e16;
        logic   prev_cs = 1'b1, prev_sclk = 1'b0, prev_done = 1'b0;
        logic   prev_cs16 = 1'b1, prev_sclk16 = 1'b0;
        logic [7:0]  p_rx = '0;
        int     p_idx = 0, cs_low = 0, busy_cnt = 0, rises = 0, viol = 0, dbl = 0;
        int     cs_low16 = 0, busy_cnt16 = 0, rises16 = 0, last_rise16 = 0, gap_bad16 = 0;
        int     deadline = 0;
        p_poci = 1'b0;
        forever begin
            @(negedge clk);
            // Peripheral and per-transfer measurements, 8-bit instance
            if (!cs && prev_cs) begin
                cs_low = 0; busy_cnt = 0; rises = 0; p_rx = '0; p_idx = 0;
                p_poci = resp[7];
            end
            if (!cs) cs_low++;
            if (busy) busy_cnt++;
            if (sclk && !prev_sclk) begin
                rises++;
                p_rx = {p_rx[6:0], pico};
            end
            if (!sclk && prev_sclk && !cs) begin
                p_idx++;
                if (p_idx < 8) p_poci = resp[7-p_idx];
            end
            if (cs && sclk) viol++;
            if (done && prev_done) dbl++;
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("rx_data", rx_data, e.rx);
                    chk("done_cycle", cyc, e.done_at);
                    chk("periph_rx", p_rx, e.tx);
                    chk("sclk_rises", rises, 8);
                    chk("cs_low_cycles", cs_low, N);
                    chk("busy_cycles", busy_cnt, N);
                end
            end
            prev_cs = cs; prev_sclk = sclk; prev_done = done;

            // 16-bit loopback instance
            if (!cs16 && prev_cs16) begin
                cs_low16 = 0; busy_cnt16 = 0; rises16 = 0;
            end
            if (!cs16) cs_low16++;
            if (busy16) busy_cnt16++;
            if (sclk16 && !prev_sclk16) begin
                if (rises16 > 0 && cyc - last_rise16 != 2) gap_bad16++;
                rises16++;
                last_rise16 = cyc;
            end
            if (done16) begin
                if (q16.size() == 0) begin
                    chk("unexpected_done16", 32'd1, 32'd0);
                end else begin
                    e16 = q16.pop_front();
                    chk("rx16", rx16, e16.rx);
                    chk("done16_cycle", cyc, e16.done_at);
                    chk("sclk16_rises", rises16, 16);
                    chk("sclk16_period_errs", gap_bad16, 0);
                    chk("cs16_low_cycles", cs_low16, N16);
                    chk("busy16_cycles", busy_cnt16, N16);
                end
            end
            prev_cs16 = cs16; prev_sclk16 = sclk16;

            if (cyc == reset_chk_at) begin
                chk("rst_cs", cs, 1);
                chk("rst_sclk", sclk, 0);
                chk("rst_pico", pico, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_rx_data", rx_data, 0);
            end

            // Predict the effect of the coming clock edge from the driven inputs
            if (reset) begin
                q.delete();
                q16.delete();
                free_at = cyc + 2;
                free16  = cyc + 2;
            end else begin
                if (start && cyc + 1 >= free_at) begin
                    q.push_back('{rx: (loop_en ? tx_data : resp), tx: tx_data,
                                  done_at: cyc + 1 + N});
                    free_at = cyc + 2 + N;
                end
                if (start16 && cyc + 1 >= free16) begin
                    q16.push_back('{rx: tx16, done_at: cyc + 1 + N16});
                    free16 = cyc + 2 + N16;
                end
            end

            if (finish_req) begin
                if (deadline == 0) deadline = cyc + 200;
                if ((q.size() == 0 && q16.size() == 0) || cyc >= deadline) begin
                    chk("pending_transfers", q.size(), 0);
                    chk("pending_transfers16", q16.size(), 0);
                    chk("sclk_while_cs_high", viol, 0);
                    chk("done_longer_than_1", dbl, 0);
                    $display("CHECKS %0d ERRORS %0d", checks, errors);
                    $finish;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] t, input logic lp, input logic [7:0] r,
                         output int t0);
        while (free_at > cyc + 1) step();
        loop_en = lp; resp = r; tx_data = t; start = 1'b1;
        t0 = cyc + 1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset_chk_at = cyc;
        reset = 1'b0;
    endtask

    initial begin : stimulus
        int t0;
        reset = 1'b1; start = 1'b0; tx_data = '0; loop_en = 1'b1; resp = '0;
        start16 = 1'b0; tx16 = '0;
        repeat (3) step();
        reset_chk_at = cyc;
        reset = 1'b0;
        step();

        // 16-bit, CLK_DIV=1 loopback runs alongside the first 8-bit tests
        tx16 = 16'hBEEF; start16 = 1'b1;
        step();
        start16 = 1'b0;

        issue(8'hAC, 1'b1, 8'h00, t0);          // loopback
        issue(8'h3C, 1'b0, 8'h5A, t0);          // peripheral returns 5A

        issue(8'hAC, 1'b1, 8'h00, t0);          // start re-pulsed while busy
        while (cyc < t0 + 9) step();
        tx_data = 8'hFF; start = 1'b1;
        step();
        start = 1'b0;

        issue(8'hC3, 1'b1, 8'h00, t0);          // reset mid-transfer
        while (cyc < t0 + 14) step();
        do_reset();
        issue(8'h81, 1'b1, 8'h00, t0);

        while (free_at > cyc + 1) step();       // start held over two transfers
        loop_en = 1'b1; tx_data = 8'h12; start = 1'b1;
        t0 = cyc + 1;
        step();
        tx_data = 8'h34;
        while (cyc < t0 + N) step();
        step();
        start = 1'b0;

        for (int i = 0; i < 25; i++) begin
            issue(8'($urandom), 1'($urandom), 8'($urandom), t0);
            if ($urandom_range(0, 1) == 1) begin
                while (cyc < t0 + int'($urandom_range(2, 30))) step();
                tx_data = 8'($urandom); start = 1'b1;
                step();
                start = 1'b0;
            end
            repeat ($urandom_range(0, 3)) step();
        end

        finish_req = 1'b1;
    end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
SPI initiator for the ML-harness SPI link; the counterpart to spi_peripheral. It accepts a parallel word with a start/busy/done handshake and generates sclk, cs and pico from the system clock. It shifts the word out MSB-first in SPI mode 0 (CPOL=0, CPHA=0) while capturing poci into a parallel receive word. It sits between host-side control logic and the spi_peripheral pins.

Parameters:
WIDTH, 8, bits per transfer (>=2)
CLK_DIV, 2, clk cycles per sclk half-period (>=1)
CS_SETUP, 1, clk cycles cs is low before the first sclk rising edge (>=1)
CS_HOLD, 1, clk cycles cs stays low after the last sclk falling edge (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a transfer; sampled only in IDLE
tx_data  input  WIDTH  word to send; captured on the accepted start edge
busy  output  1  high from the accepted start until done
done  output  1  one-cycle pulse; rx_data is valid
rx_data  output  WIDTH  word received on poci; holds until the next done
sclk  output  1  SPI clock; idles low
cs  output  1  chip select, active low; idles high
pico  output  1  controller-out data
poci  input  1  peripheral-out data; same clock domain, not synchronised

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- All outputs are registered.
- Reset values: cs=1, sclk=0, pico=0, busy=0, done=0, rx_data=0, FSM=IDLE, all counters=0.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- IDLE:
  - start=1 at edge T0 latches tx_data into the shift register.
  - At T0: cs=0, busy=1, pico=tx_data[WIDTH-1]; go to SETUP.
  - start=0: outputs stay at idle values.
- SETUP:
  - sclk=0 for CS_SETUP cycles, then go to SHIFT.
- SHIFT: each bit takes 2*CLK_DIV cycles: CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1.
  - Rising-edge clk cycle (the clk edge that registers sclk 0->1): sample poci into rx shift register LSB; shift left.
  - Falling-edge clk cycle (the clk edge that registers sclk 1->0), bits 0..WIDTH-2: drive pico with the next bit.
  - After the WIDTH-th falling edge: sclk=0, pico held, go to HOLD.
- HOLD:
  - cs stays low for CS_HOLD cycles.
  - Then, on the same edge: cs=1, pico=0, busy=0, done=1, rx_data=captured word; go to IDLE.
- Latency: cs is low for exactly N = CS_SETUP + 2*CLK_DIV*WIDTH + CS_HOLD cycles. done is asserted by edge T0+N. Defaults give N=34.
- done is high for exactly one cycle.
- start asserted in the done cycle is accepted (FSM is IDLE) → back-to-back transfers with cs high for exactly one cycle between them.
- start while busy=1 is ignored; tx_data changes while busy do not affect the transfer in progress.
- Exactly WIDTH sclk rising edges per transfer; no sclk toggling while cs=1.
- Reset mid-transfer: next cycle returns to reset values.
  - No done pulse; rx_data is cleared to 0.
  - A partially received word is discarded.
- Bit counter width is clog2(WIDTH)+1; divider counter width is clog2(CLK_DIV)+1; no wrap beyond WIDTH bits.

Test Plan:
1. Loopback (poci=pico), tx_data=8'hAC, one start pulse -> pico bit sequence 1,0,1,0,1,1,0,0 on rising sclk; 8 sclk pulses; done at T0+34; rx_data=8'hAC; cs back to 1.
2. spi_peripheral model returning 8'h5A, tx_data=8'h3C -> the peripheral receives 8'h3C; rx_data=8'h5A; busy high for exactly 34 cycles.
3. start re-pulsed at T0+10 with tx_data=8'hFF while busy -> ignored; rx_data (loopback)=8'hAC; exactly 8 sclk rising edges.
4. reset at T0+15 -> next cycle cs=1, sclk=0, busy=0, rx_data=0; no done pulse; a following transfer of 8'h81 completes with rx_data=8'h81.
5. start held high continuously with tx_data 8'h12 then 8'h34 -> two transfers; cs high exactly one cycle between them; done pulses 35 cycles apart; rx_data=8'h12, then 8'h34.
6. CLK_DIV=1, WIDTH=16, tx_data=16'hBEEF loopback -> sclk period 2 clk cycles; done at T0+34; rx_data=16'hBEEF.
